// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for one thread's register file write port.
// Optional scoreboard of pending writes enabled by defining WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8,
    parameter int RO_BASE   = 13
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [ADDR_BITS-1:0]           rf_write_addr,
    output logic [DATA_BITS-1:0]           rf_write_data,
    output logic                           rf_write_enable,
    output logic                           ro_violation,
    output logic [7:0]                     ro_violation_count,
    input  logic                           rsv_valid,
    input  logic [ADDR_BITS-1:0]           rsv_addr,
    output logic [2**ADDR_BITS-1:0]        reg_busy
);

    localparam int          PTR_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_REGS  = 2 ** ADDR_BITS;
    localparam int unsigned NREQ_U    = NUM_REQ;
    localparam int unsigned RO_BASE_U = RO_BASE;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("regfile_wb_arbiter: NUM_REQ must be within 2..8");
    end

    function automatic logic is_ro(input logic [ADDR_BITS-1:0] a);
        return (32'(a) >= RO_BASE_U);
    endfunction

    logic [PTR_BITS-1:0]  rr_ptr;
    logic                 grant_found;
    logic [PTR_BITS-1:0]  grant_idx;
    logic [PTR_BITS-1:0]  grant_next;
    logic [ADDR_BITS-1:0] grant_addr;
    logic [DATA_BITS-1:0] grant_data;
    logic                 grant_is_ro;
    logic                 transfer;

    // Search starts at rr_ptr and wraps; only the valid bits steer the grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_next  = '0;
        grant_addr  = '0;
        grant_data  = '0;
        for (int unsigned offs = 0; offs < NREQ_U; offs++) begin
            int unsigned cand;
            cand = (32'(rr_ptr) + offs) % NREQ_U;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_BITS'(cand);
                grant_next  = PTR_BITS'((cand + 1) % NREQ_U);
                grant_addr  = req_addr[cand*ADDR_BITS +: ADDR_BITS];
                grant_data  = req_data[cand*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign grant_is_ro = is_ro(grant_addr);
    assign transfer    = grant_found && !stall && !reset;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr             <= '0;
            rf_write_enable    <= 1'b0;
            rf_write_addr      <= '0;
            rf_write_data      <= '0;
            ro_violation       <= 1'b0;
            ro_violation_count <= '0;
        end else begin
            rf_write_enable <= 1'b0;
            ro_violation    <= 1'b0;
            if (transfer) begin
                rr_ptr <= grant_next;
                // Read-only targets are consumed but never reach the port.
                if (grant_is_ro) begin
                    ro_violation <= 1'b1;
                    if (ro_violation_count != '1) begin
                        ro_violation_count <= ro_violation_count + 8'd1;
                    end
                end else begin
                    rf_write_enable <= 1'b1;
                    rf_write_addr   <= grant_addr;
                    rf_write_data   <= grant_data;
                end
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;

    // Clear on the commit edge first so a same-edge reserve wins.
    always_comb begin
        busy_next = busy_q;
        if (rf_write_enable) begin
            busy_next[rf_write_addr] = 1'b0;
        end
        if (rsv_valid && !is_ro(rsv_addr)) begin
            busy_next[rsv_addr] = 1'b1;
        end
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (r >= RO_BASE_U) begin
                busy_next[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign reg_busy = busy_q;
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_valid, rsv_addr};
    assign reg_busy   = '0;
`endif

endmodule
